mem_port_arb: RTL and testbench
===============================

MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter ADDR_W, 14, memory word-address width.
REQ-002 Parameter DATA_W, 64, memory data width.
REQ-003 Parameter RD_LAT, 1, memory read latency in clk cycles (legal range 1..4).
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  100 MHz system clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 mem_sys_fin  in  1  high = memory released by CPU side; arbiter may issue accesses.
REQ-008 ld_req, ld_we, ld_addr, ld_wdata  in  1,1,ADDR_W,DATA_W  loader requester (read or write).
REQ-009 ld_gnt, ld_rvalid, ld_rdata  out  1,1,DATA_W  loader grant, read-return strobe, read data.
REQ-010 dsp_req, dsp_urgent, dsp_addr  in  1,1,ADDR_W  display requester (read-only); urgent = display FIFO low.
REQ-011 dsp_gnt, dsp_rvalid, dsp_rdata  out  1,1,DATA_W  display grant, read-return strobe, read data.
REQ-012 enb, web, addrb, dinb  out  1,1,ADDR_W,DATA_W  memory port B command.
REQ-013 doutb  in  DATA_W  memory port B read data.
REQ-014 busy  out  1  high when state is not HOLD or reads are in flight.

Function
REQ-015 FSM states HOLD, RUN, DRAIN; grants issue only in RUN.
REQ-016 HOLD->RUN when mem_sys_fin=1; RUN->DRAIN when mem_sys_fin=0; DRAIN->HOLD when no reads in flight (immediately if none).
REQ-017 DRAIN->RUN if mem_sys_fin returns to 1 before drain completes.
REQ-018 At most one grant per cycle; gnt is combinational in the request cycle; accepted access = req & gnt.
REQ-019 Priority: dsp_req & dsp_urgent wins; otherwise round-robin via a 1-bit last-winner pointer.
REQ-020 Pointer updates on every grant to the granted requester, including urgent grants.
REQ-021 Single requester in RUN is granted every cycle it requests.
REQ-022 enb=1 exactly in grant cycles; web=ld_we when loader granted, 0 otherwise; addrb/dinb from winner; dinb=0 when display granted.
REQ-023 enb=0, web=0, addrb=0, dinb=0 when no grant.
REQ-024 Each granted read pushes an owner tag into an RD_LAT-deep valid/owner shift pipeline; writes push nothing.
REQ-025 Exactly RD_LAT cycles after a read grant, the owner's rvalid pulses 1 cycle with rdata=doutb; the other rvalid stays 0.
REQ-026 rdata outputs are driven from doutb unconditionally; only rvalid qualifies them.
REQ-027 Back-to-back reads (any owner mix) return in issue order, one per cycle, no bubbles inserted.
REQ-028 Reads in flight at a RUN->DRAIN transition still complete and return rvalid.
REQ-029 Write grant followed next cycle by read grant to the same address returns the new data (memory is write-first; arbiter adds no hazard logic).

Reset
REQ-030 rst forces state=HOLD, pointer=display-last (loader wins first tie), pipeline cleared.
REQ-031 During and after rst: all gnt, rvalid, enb, web =0, addrb=0, dinb=0, busy=0.
REQ-032 Reads in flight at rst assertion are discarded; no rvalid after reset release.

Structure
REQ-033 Shared package holds state encoding (HOLD=0, RUN=1, DRAIN=2), owner-tag encoding (LD=0, DSP=1), and ADDR_W/DATA_W defaults.
REQ-034 One sub-module, rd_tag_pipe: parameterised RD_LAT-deep shift register of {valid, owner}, with in-flight-count output.

Verification
REQ-035 Both req every cycle, no urgent, 8 cycles -> grants alternate LD,DSP,LD,... starting LD after reset.
REQ-036 dsp_req & dsp_urgent with ld_req for 5 cycles -> dsp_gnt all 5, ld_gnt 0; on urgent drop, next grant LD.
REQ-037 LD write addr 0x0010 data 0xDEAD_BEEF_0000_0001, then DSP read 0x0010 -> dsp_rvalid RD_LAT cycles later with that data, ld_rvalid 0.
REQ-038 Alternate LD read 0x0001 / DSP read 0x0002 four times, mem_sys_fin dropped after 3rd grant -> state DRAIN, no 4th grant, 3 rvalids in order, then HOLD.
REQ-039 mem_sys_fin=0 with both requesting -> no gnt, enb=0, busy=0 indefinitely.
REQ-040 rst asserted one cycle after a read grant -> no rvalid ever returned; all outputs 0 next edge.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state and read-owner
// encodings, default widths, and a width helper for in-flight counters.
package mem_port_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    OWN_LD  = 1'b0,
    OWN_DSP = 1'b1
  } owner_e;

  // Bits needed to count 0..depth in-flight entries.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_port_arb_rd_tag_pipe.sv
// Read tag pipeline: DEPTH-deep shift register of {valid, owner} that tracks
// reads issued to the memory until their data appears on doutb.
//   clk, rst          : clock, asynchronous active-high reset (clears all tags)
//   push_valid/owner  : read issued this cycle and who issued it
//   pop_valid/owner   : read whose data is on doutb this cycle
//   inflight          : number of valid tags currently in the pipe
module mem_port_arb_rd_tag_pipe
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned DEPTH = RD_LAT_DEF,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  owner_e           push_owner,
  output logic             pop_valid,
  output owner_e           pop_owner,
  output logic [CNT_W-1:0] inflight
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] owner_q, owner_d;

  // Shift in at bit 0; the truncating cast drops the oldest entry and also
  // covers DEPTH == 1 without a zero-width slice.
  always_comb begin
    valid_d = DEPTH'({valid_q, push_valid});
    owner_d = DEPTH'({owner_q, (push_valid && (push_owner == OWN_DSP))});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    pop_valid = valid_q[DEPTH-1];
    pop_owner = owner_q[DEPTH-1] ? OWN_DSP : OWN_LD;
    inflight  = CNT_W'($countones(valid_q));
  end

endmodule

// File: rtl/mem_port_arb.sv
// Two-requester arbiter for memory port B. The loader (read/write) and the
// display (read-only, with an urgent override) share the port once the CPU
// side has released memory (mem_sys_fin). Grants are combinational in the
// request cycle; read data returns RD_LAT cycles later with an owner strobe.
//   clk, rst                     : clock, asynchronous active-high reset
//   mem_sys_fin                  : memory released by CPU side
//   ld_req/we/addr/wdata         : loader request
//   ld_gnt/rvalid/rdata          : loader grant and read return
//   dsp_req/urgent/addr          : display request
//   dsp_gnt/rvalid/rdata         : display grant and read return
//   enb/web/addrb/dinb, doutb    : memory port B
//   busy                         : not idle in HOLD, or reads still returning
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_sys_fin,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              dsp_req,
  input  logic              dsp_urgent,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic              dsp_gnt,
  output logic              dsp_rvalid,
  output logic [DATA_W-1:0] dsp_rdata,
  output logic              enb,
  output logic              web,
  output logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dinb,
  input  logic [DATA_W-1:0] doutb,
  output logic              busy
);

  localparam int unsigned CNT_W = cnt_width(RD_LAT);

  state_e           state_q, state_d;
  owner_e           ptr_q, ptr_d;
  logic             ld_win, dsp_win;
  logic             push_valid;
  owner_e           push_owner;
  logic             pop_valid;
  owner_e           pop_owner;
  logic [CNT_W-1:0] inflight;

  // State and last-winner pointer; display-last after reset so the loader
  // wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HOLD;
      ptr_q   <= OWN_DSP;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: DRAIN waits for issued reads to come back before HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD:  if (mem_sys_fin) state_d = ST_RUN;
      ST_RUN:   if (!mem_sys_fin) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (mem_sys_fin)          state_d = ST_RUN;
        else if (inflight == '0)  state_d = ST_HOLD;
      end
      default:  state_d = ST_HOLD;
    endcase
  end

  // Arbitration and port drive. No access is issued in the cycle the CPU
  // side reclaims memory, even though the state is still RUN.
  always_comb begin
    ld_win     = 1'b0;
    dsp_win    = 1'b0;
    ptr_d      = ptr_q;
    enb        = 1'b0;
    web        = 1'b0;
    addrb      = '0;
    dinb       = '0;
    push_valid = 1'b0;
    push_owner = OWN_LD;

    if ((state_q == ST_RUN) && mem_sys_fin) begin
      if (dsp_req && dsp_urgent)  dsp_win = 1'b1;
      else if (ld_req && dsp_req) begin
        if (ptr_q == OWN_DSP)     ld_win  = 1'b1;
        else                      dsp_win = 1'b1;
      end
      else if (ld_req)            ld_win  = 1'b1;
      else if (dsp_req)           dsp_win = 1'b1;
    end

    if (ld_win) begin
      ptr_d      = OWN_LD;
      enb        = 1'b1;
      web        = ld_we;
      addrb      = ld_addr;
      dinb       = ld_wdata;
      push_valid = !ld_we;
      push_owner = OWN_LD;
    end else if (dsp_win) begin
      ptr_d      = OWN_DSP;
      enb        = 1'b1;
      addrb      = dsp_addr;
      push_valid = 1'b1;
      push_owner = OWN_DSP;
    end

    ld_gnt     = ld_win;
    dsp_gnt    = dsp_win;
    ld_rvalid  = pop_valid && (pop_owner == OWN_LD);
    dsp_rvalid = pop_valid && (pop_owner == OWN_DSP);
    ld_rdata   = doutb;
    dsp_rdata  = doutb;
    busy       = (state_q != ST_HOLD) || (inflight != '0);
  end

  mem_port_arb_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_owner (push_owner),
    .pop_valid  (pop_valid),
    .pop_owner  (pop_owner),
    .inflight   (inflight)
  );

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb with a write-first, 1-cycle-latency memory model.
module tb_mem_port_arb;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_sys_fin = 1'b0;
  logic              ld_req = 1'b0, ld_we = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_wdata = '0;
  logic              ld_gnt, ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic              dsp_req = 1'b0, dsp_urgent = 1'b0;
  logic [ADDR_W-1:0] dsp_addr = '0;
  logic              dsp_gnt, dsp_rvalid;
  logic [DATA_W-1:0] dsp_rdata;
  logic              enb, web;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dinb;
  logic [DATA_W-1:0] doutb = '0;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arb #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_sys_fin(mem_sys_fin),
    .ld_req     (ld_req),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_gnt     (ld_gnt),
    .ld_rvalid  (ld_rvalid),
    .ld_rdata   (ld_rdata),
    .dsp_req    (dsp_req),
    .dsp_urgent (dsp_urgent),
    .dsp_addr   (dsp_addr),
    .dsp_gnt    (dsp_gnt),
    .dsp_rvalid (dsp_rvalid),
    .dsp_rdata  (dsp_rdata),
    .enb        (enb),
    .web        (web),
    .addrb      (addrb),
    .dinb       (dinb),
    .doutb      (doutb),
    .busy       (busy)
  );

  // Memory: unwritten words read back a fixed pattern of their address.
  logic [63:0]  mem [0:255];
  logic [255:0] wr_seen = '0;

  function automatic logic [63:0] init_word(input int unsigned a);
    return 64'h1000_0000_0000_0000 + 64'(a);
  endfunction

  always @(posedge clk) begin
    if (enb) begin
      if (web) begin
        mem[addrb[7:0]]     <= dinb;
        wr_seen[addrb[7:0]] <= 1'b1;
        doutb               <= dinb;
      end else begin
        doutb <= wr_seen[addrb[7:0]] ? mem[addrb[7:0]] : init_word(32'(addrb[7:0]));
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ld_gnt"},  64'(ld_gnt),  64'd0);
    chk({tag, "_dsp_gnt"}, 64'(dsp_gnt), 64'd0);
    chk({tag, "_enb"},     64'(enb),     64'd0);
    chk({tag, "_web"},     64'(web),     64'd0);
    chk({tag, "_addrb"},   64'(addrb),   64'd0);
    chk({tag, "_dinb"},    dinb,         64'd0);
  endtask

  task automatic chk_rv(input string tag, input logic exp_ld, input logic exp_dsp,
                        input logic [63:0] exp_data);
    chk({tag, "_ld_rvalid"},  64'(ld_rvalid),  64'(exp_ld));
    chk({tag, "_dsp_rvalid"}, 64'(dsp_rvalid), 64'(exp_dsp));
    if (exp_ld)  chk({tag, "_ld_rdata"},  ld_rdata,  exp_data);
    if (exp_dsp) chk({tag, "_dsp_rdata"}, dsp_rdata, exp_data);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic exp_ld;

    // Reset held with both requesters active and memory released.
    ld_req = 1'b1; dsp_req = 1'b1; mem_sys_fin = 1'b1;
    tick(); tick(); #1;
    chk_idle("rst");
    chk_rv("rst", 1'b0, 1'b0, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Memory still owned by CPU: requests must be ignored.
    tick(); rst = 1'b0; mem_sys_fin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_idle($sformatf("nofin%0d", k));
      chk($sformatf("nofin%0d_busy", k), 64'(busy), 64'd0);
      tick();
    end

    // Release memory; both requesters stream reads -> LD,DSP,LD,...
    mem_sys_fin = 1'b1; ld_req = 1'b0; dsp_req = 1'b0;
    ld_we = 1'b0; ld_addr = 14'h0005; dsp_addr = 14'h0006;
    #1;
    chk("hold_state", 64'(dut.state_q), 64'd0);
    for (int k = 0; k < 8; k++) begin
      tick(); ld_req = 1'b1; dsp_req = 1'b1; #1;
      exp_ld = (k % 2 == 0);
      chk($sformatf("rr%0d_ld_gnt", k),  64'(ld_gnt),  64'(exp_ld));
      chk($sformatf("rr%0d_dsp_gnt", k), 64'(dsp_gnt), 64'(!exp_ld));
      chk($sformatf("rr%0d_addrb", k),   64'(addrb),   exp_ld ? 64'h5 : 64'h6);
      if (k == 0) begin
        chk("rr0_busy", 64'(busy), 64'd1);
        chk_rv("rr0", 1'b0, 1'b0, 64'd0);
      end else begin
        chk_rv($sformatf("rr%0d", k), !exp_ld, exp_ld,
               exp_ld ? init_word(6) : init_word(5));
      end
    end
    tick(); ld_req = 1'b0; dsp_req = 1'b0; #1;
    chk_rv("rr_tail", 1'b0, 1'b1, init_word(6));
    chk_idle("rr_tail");

    // Urgent display preempts the loader; loader wins once urgency drops.
    for (int k = 0; k < 5; k++) begin
      tick(); ld_req = 1'b1; dsp_req = 1'b1; dsp_urgent = 1'b1; #1;
      chk($sformatf("urg%0d_dsp_gnt", k), 64'(dsp_gnt), 64'd1);
      chk($sformatf("urg%0d_ld_gnt", k),  64'(ld_gnt),  64'd0);
    end
    tick(); dsp_urgent = 1'b0; #1;
    chk("urg_drop_ld_gnt",  64'(ld_gnt),  64'd1);
    chk("urg_drop_dsp_gnt", 64'(dsp_gnt), 64'd0);

    // Loader write then display read of the same word returns new data.
    tick(); dsp_req = 1'b0; ld_req = 1'b1; ld_we = 1'b1;
    ld_addr = 14'h0010; ld_wdata = 64'hDEAD_BEEF_0000_0001; #1;
    chk("wr_ld_gnt", 64'(ld_gnt), 64'd1);
    chk("wr_enb",    64'(enb),    64'd1);
    chk("wr_web",    64'(web),    64'd1);
    chk("wr_addrb",  64'(addrb),  64'h10);
    chk("wr_dinb",   dinb,        64'hDEAD_BEEF_0000_0001);
    chk_rv("wr", 1'b1, 1'b0, init_word(5));
    tick(); ld_req = 1'b0; ld_we = 1'b0; dsp_req = 1'b1; dsp_addr = 14'h0010; #1;
    chk("rd_dsp_gnt", 64'(dsp_gnt), 64'd1);
    chk("rd_web",     64'(web),     64'd0);
    chk("rd_dinb",    dinb,         64'd0);
    chk("rd_addrb",   64'(addrb),   64'h10);
    chk_rv("rd", 1'b0, 1'b0, 64'd0);
    tick(); dsp_req = 1'b0; #1;
    chk_rv("rd_ret", 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
    chk_idle("rd_ret");

    // Alternating reads; memory reclaimed after the third grant.
    ld_addr = 14'h0001; dsp_addr = 14'h0002;
    for (int k = 0; k < 3; k++) begin
      tick(); ld_req = 1'b1; dsp_req = 1'b1; #1;
      exp_ld = (k != 1);
      chk($sformatf("dr%0d_ld_gnt", k),  64'(ld_gnt),  64'(exp_ld));
      chk($sformatf("dr%0d_dsp_gnt", k), 64'(dsp_gnt), 64'(!exp_ld));
      if (k == 0) chk_rv("dr0", 1'b0, 1'b0, 64'd0);
      if (k == 1) chk_rv("dr1", 1'b1, 1'b0, init_word(1));
      if (k == 2) chk_rv("dr2", 1'b0, 1'b1, init_word(2));
    end
    tick(); mem_sys_fin = 1'b0; #1;
    chk_idle("dr3");
    chk_rv("dr3", 1'b1, 1'b0, init_word(1));
    chk("dr3_busy", 64'(busy), 64'd1);
    tick(); ld_req = 1'b0; dsp_req = 1'b0; #1;
    chk("dr4_state", 64'(dut.state_q), 64'd2);
    chk("dr4_busy",  64'(busy),        64'd1);
    chk_rv("dr4", 1'b0, 1'b0, 64'd0);
    chk_idle("dr4");
    tick(); #1;
    chk("dr5_state", 64'(dut.state_q), 64'd0);
    chk("dr5_busy",  64'(busy),        64'd0);

    // Reset one cycle after a read grant discards the read.
    tick(); mem_sys_fin = 1'b1; #1;
    tick(); ld_req = 1'b1; ld_addr = 14'h0003; #1;
    chk("rr_rst_ld_gnt", 64'(ld_gnt), 64'd1);
    tick(); ld_req = 1'b0; rst = 1'b1; mem_sys_fin = 1'b0; #1;
    chk_rv("mid_rst", 1'b0, 1'b0, 64'd0);
    chk_idle("mid_rst");
    chk("mid_rst_busy", 64'(busy), 64'd0);
    tick(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_rv($sformatf("post_rst%0d", k), 1'b0, 1'b0, 64'd0);
      chk($sformatf("post_rst%0d_busy", k), 64'(busy), 64'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
